// File: rtl/pa_isa_pkg.sv
// pa_isa_pkg: instruction field layout, bundle widths and decoded-instruction type shared by fetch/decode.
package pa_isa_pkg;
   localparam int INSTR_W  = 30;
   localparam int BUNDLE_W = 60;
   localparam int FMT_BIT  = 29;
   localparam int BR_BIT   = 28;
   localparam int OPC_HI   = 27;
   localparam int OPC_LO   = 21;
   localparam int RD_HI    = 20;
   localparam int RD_LO    = 16;
   localparam int RS_HI    = 15;
   localparam int RS_LO    = 11;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;
   localparam logic [6:0] OPC_NOP = 7'h00;

   typedef struct packed {
      logic        fmt;
      logic        branch;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs;
      logic [15:0] imm;
   } dec_t;

   function automatic dec_t decode(input logic [INSTR_W-1:0] i);
      decode.fmt    = i[FMT_BIT];
      decode.branch = i[BR_BIT];
      decode.opcode = i[OPC_HI:OPC_LO];
      decode.rd     = i[RD_HI:RD_LO];
      decode.rs     = i[RS_HI:RS_LO];
      decode.imm    = i[IMM_HI:IMM_LO];
   endfunction
endpackage

// File: rtl/bundle_fifo.sv
// bundle_fifo: count-tracked bundle FIFO; full/empty come from count so wrapped pointers never alias.
module bundle_fifo import pa_isa_pkg::*; #(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                push,
   input  logic                pop,
   input  logic                flush,
   input  logic [BUNDLE_W-1:0] wdata,
   output logic [BUNDLE_W-1:0] head,
   output logic [CW-1:0]       count,
   output logic                full,
   output logic                empty
);
   logic [BUNDLE_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr, rd;
   logic wr_en, rd_en;

   always_comb begin
      full  = count == CW'(DEPTH);
      empty = count == '0;
      wr_en = push && !full && !flush;
      rd_en = pop && !empty && !flush;
      head  = mem[rd];
   end

   always_ff @(posedge clock_i or negedge reset_i)
      if (!reset_i) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else if (flush) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else begin
         if (wr_en) wr <= wr + AW'(1);
         if (rd_en) rd <= rd + AW'(1);
         count <= count + CW'(wr_en) - CW'(rd_en);
      end

   always_ff @(posedge clock_i)
      if (wr_en) mem[wr] <= wdata;
endmodule

// File: rtl/decode_issue.sv
// decode_issue: buffers two-instruction bundles and issues one decoded instruction per cycle.
// Build option DECODE_NOP_SQUASH_EN drops opcode-zero slots instead of issuing them.
module decode_issue import pa_isa_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                enable_i,
   input  logic [BUNDLE_W-1:0] data_i,
   input  logic                flush_i,
   input  logic                ready_i,
   output logic                stall_o,
   output logic                valid_o,
   output logic                fmt_o,
   output logic                branch_o,
   output logic [6:0]          opcode_o,
   output logic [4:0]          rd_o,
   output logic [4:0]          rs_o,
   output logic [15:0]         imm_o,
   output logic                overflow_o
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [BUNDLE_W-1:0] head;
   logic [INSTR_W-1:0] src;
   logic [CW-1:0] count, cnt_n;
   logic full, empty, slot, take, load, push, pop;
   dec_t dq;

   bundle_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock_i(clock_i),
      .reset_i(reset_i),
      .push(push),
      .pop(pop),
      .flush(flush_i),
      .wdata(data_i),
      .head(head),
      .count(count),
      .full(full),
      .empty(empty)
   );

   always_comb begin
      src  = slot ? head[INSTR_W-1:0] : head[BUNDLE_W-1:INSTR_W];
      take = (!valid_o || ready_i) && !empty && !flush_i;
      pop  = take && slot;
      push = enable_i && !full && !flush_i;
`ifdef DECODE_NOP_SQUASH_EN
      load = take && src[OPC_HI:OPC_LO] != OPC_NOP;
`else
      load = take;
`endif
      cnt_n = flush_i ? '0 : count + CW'(push) - CW'(pop);
   end

   // stall leaves one entry free for the bundle fetch already has in flight
   always_ff @(posedge clock_i or negedge reset_i)
      if (!reset_i) begin
         slot       <= 1'b0;
         valid_o    <= 1'b0;
         stall_o    <= 1'b0;
         overflow_o <= 1'b0;
         dq         <= '0;
      end else begin
         stall_o <= cnt_n >= CW'(DEPTH - 1);
         if (enable_i && full && !flush_i) overflow_o <= 1'b1;
         if (flush_i) begin
            slot    <= 1'b0;
            valid_o <= 1'b0;
         end else if (take) begin
            slot    <= !slot;
            valid_o <= load;
            if (load) dq <= decode(src);
         end else if (ready_i) valid_o <= 1'b0;
      end

   assign fmt_o    = dq.fmt;
   assign branch_o = dq.branch;
   assign opcode_o = dq.opcode;
   assign rd_o     = dq.rd;
   assign rs_o     = dq.rs;
   assign imm_o    = dq.imm;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: instruction-stream scoreboard for decode_issue with directed and random traffic.
module tb_decode_issue;
   localparam int DEPTH = 4;

   logic clock_i = 1'b0, reset_i = 1'b0, enable_i = 1'b0, flush_i = 1'b0, ready_i = 1'b0;
   logic [59:0] data_i = '0;
   logic stall_o, valid_o, fmt_o, branch_o, overflow_o;
   logic [6:0] opcode_o;
   logic [4:0] rd_o, rs_o;
   logic [15:0] imm_o;

   decode_issue #(.DEPTH(DEPTH)) dut (
      .clock_i(clock_i),
      .reset_i(reset_i),
      .enable_i(enable_i),
      .data_i(data_i),
      .flush_i(flush_i),
      .ready_i(ready_i),
      .stall_o(stall_o),
      .valid_o(valid_o),
      .fmt_o(fmt_o),
      .branch_o(branch_o),
      .opcode_o(opcode_o),
      .rd_o(rd_o),
      .rs_o(rs_o),
      .imm_o(imm_o),
      .overflow_o(overflow_o)
   );

   always #5 clock_i = ~clock_i;

   int n_chk = 0, n_fail = 0;
   logic [29:0] iq[$];
   logic [29:0] exp_q[$];
   logic mv = 1'b0, ms = 1'b0, movf = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic is_nop(input logic [29:0] i);
`ifdef DECODE_NOP_SQUASH_EN
      return i[27:21] == 7'd0;
`else
      return 1'b0;
`endif
   endfunction

   // reference: pending instructions in fetch order; bundles held = ceil(pending/2)
   always @(posedge clock_i or negedge reset_i)
      if (!reset_i) begin
         iq.delete();
         exp_q.delete();
         mv = 1'b0;
         ms = 1'b0;
         movf = 1'b0;
      end else begin
         int cnt;
         logic [29:0] ins;
         cnt = (iq.size() + 1) / 2;
         if (flush_i) begin
            iq.delete();
            exp_q.delete();
            mv = 1'b0;
         end else begin
            if ((!mv || ready_i) && iq.size() > 0) begin
               ins = iq.pop_front();
               if (is_nop(ins)) mv = 1'b0;
               else begin
                  exp_q.push_back(ins);
                  mv = 1'b1;
               end
            end else if (ready_i) mv = 1'b0;
            if (enable_i) begin
               if (cnt < DEPTH) begin
                  iq.push_back(data_i[59:30]);
                  iq.push_back(data_i[29:0]);
               end else movf = 1'b1;
            end
         end
         ms = (iq.size() + 1) / 2 >= DEPTH - 1;
      end

   always @(negedge clock_i)
      if (reset_i) begin
         logic [29:0] e;
         check("valid", valid_o, mv);
         check("stall", stall_o, ms);
         check("overflow", overflow_o, movf);
         if (valid_o) begin
            if (exp_q.size() == 0) check("spurious_valid", exp_q.size(), 1);
            else begin
               e = exp_q[0];
               check("fields", {fmt_o, branch_o, opcode_o, rd_o, rs_o, imm_o},
                     {e[29], e[28], e[27:21], e[20:16], e[15:11], e[15:0]});
               if (ready_i) void'(exp_q.pop_front());
            end
         end
      end

   task automatic cyc(input logic en, input logic [59:0] d, input logic rdy, input logic fl);
      enable_i = en;
      data_i = d;
      ready_i = rdy;
      flush_i = fl;
      @(posedge clock_i);
      #1;
   endtask

   function automatic logic [29:0] rnd_instr();
      logic [29:0] r;
      r = 30'($urandom);
      if ($urandom_range(0, 3) == 0) r[27:21] = 7'd0;
      return r;
   endfunction

   initial begin
      int sent;
      logic [29:0] a, b;
      repeat (2) @(posedge clock_i);
      #1 reset_i = 1'b1;
      a = {2'b00, 7'd9, 5'd3, 16'h1234};
      cyc(1'b1, {a, rnd_instr()}, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      #3 reset_i = 1'b0;
      #1;
      check("rst_valid", valid_o, 0);
      check("rst_stall", stall_o, 0);
      check("rst_overflow", overflow_o, 0);
      check("rst_fields", {fmt_o, branch_o, opcode_o, rd_o, rs_o, imm_o}, 0);
      #2 reset_i = 1'b1;
      a = {1'b1, 1'b0, 7'd4, 5'd1, 16'h000A};
      b = {1'b1, 1'b0, 7'd4, 5'd2, 16'h0005};
      cyc(1'b1, {a, b}, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("lat_slot0", {valid_o, opcode_o, rd_o, imm_o}, {1'b1, 7'd4, 5'd1, 16'h000A});
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("lat_slot1", {valid_o, opcode_o, rd_o, imm_o}, {1'b1, 7'd4, 5'd2, 16'h0005});
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("lat_done", valid_o, 0);
      repeat (6) cyc(1'b1, {rnd_instr(), rnd_instr()}, 1'b0, 1'b0);
      repeat (12) cyc(1'b0, '0, 1'b1, 1'b0);
      repeat (3) cyc(1'b1, {rnd_instr(), rnd_instr()}, 1'b0, 1'b0);
      cyc(1'b1, {rnd_instr(), rnd_instr()}, 1'b0, 1'b1);
      check("flush_valid", valid_o, 0);
      check("flush_stall", stall_o, 0);
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
      a = {2'b00, 7'd1, 5'd1, 5'd2, 11'd0};
      cyc(1'b1, {a, 30'd0}, 1'b1, 1'b0);
      repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
      sent = 0;
      for (int c = 0; c < 300 && sent < 10; c++) begin
         if (!stall_o) begin
            cyc(1'b1, {rnd_instr(), rnd_instr()}, 1'(c % 2), 1'b0);
            sent++;
         end else cyc(1'b0, '0, 1'(c % 2), 1'b0);
      end
      check("wrap_sent", sent, 10);
      for (int c = 0; c < 400; c++)
         cyc($urandom_range(0, 1) == 1 && (!stall_o || $urandom_range(0, 7) == 0),
             {rnd_instr(), rnd_instr()}, 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
      for (int c = 0; c < 200 && (iq.size() > 0 || mv); c++) cyc(1'b0, '0, 1'b1, 1'b0);
      check("drain_left", iq.size(), 0);
      check("drain_valid", valid_o, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Sits directly downstream of the fetch stage.
- Accepts 60-bit two-instruction bundles from fetch and buffers them in a small bundle FIFO.
- Splits each bundle into its two 30-bit instructions, decodes the fields, and issues one instruction per cycle to execute over a valid/ready handshake.
- Drives stall_o back to PC generation so fetch holds the PC before the FIFO overflows.

Parameters:
- DEPTH, 4: bundle FIFO entries; power of two, ≥ 2.

Ports:
- clock_i  in  1  single clock; all state on rising edge.
- reset_i  in  1  reset, asynchronous, active-low.
- enable_i  in  1  fetch bundle valid this cycle.
- data_i  in  60  bundle; [59:30] = slot 0 (issues first), [29:0] = slot 1.
- flush_i  in  1  discard all buffered and pending instructions.
- ready_i  in  1  execute accepts the current output.
- stall_o  out  1  tell PC logic to hold the PC.
- valid_o  out  1  decoded instruction present.
- fmt_o  out  1  instr[29]: 1 = register-immediate, 0 = register-register.
- branch_o  out  1  instr[28].
- opcode_o  out  7  instr[27:21].
- rd_o  out  5  instr[20:16], primary operand.
- rs_o  out  5  instr[15:11]; valid only when fmt = 0.
- imm_o  out  16  instr[15:0]; valid only when fmt = 1.
- overflow_o  out  1  sticky: a bundle arrived while the FIFO was full.

Behaviour:
- Reset (reset_i low, asynchronous):
  - FIFO pointers, count and slot pointer go to 0.
  - valid_o, stall_o, overflow_o, and all field outputs go to 0.
  - Deassertion takes effect on the next rising edge.
- FIFO write:
  - enable_i high at edge N with count < DEPTH: data_i is written and count increments.
  - If count == DEPTH: the bundle is dropped and overflow_o is set; it clears only on reset.
- stall_o is registered, = (count_next >= DEPTH-1). This leaves one free entry to absorb the bundle already in flight from fetch.
- Issue:
  - The output register loads when (!valid_o || ready_i) and the FIFO is non-empty.
  - Source: slot 0 of the head entry if slot pointer = 0, otherwise slot 1.
  - Loading slot 0 sets the slot pointer to 1.
  - Loading slot 1 pops the head and clears the slot pointer.
  - The same edge may write and pop; count is then unchanged.
- Hold: while valid_o && !ready_i, all outputs stay stable.
- Empty: when valid_o && ready_i and there is no source, valid_o drops to 0 and the field outputs hold their last values.
- Latency: a bundle written at edge N into an empty FIFO with a free output gives valid_o high after edge N+1 (slot 0), then slot 1 after N+2 if ready_i stays high.
- Throughput: one instruction per cycle, i.e. one bundle per two cycles. Sustained fetch therefore fills the FIFO and stall_o throttles it.
- Flush:
  - flush_i at an edge empties the FIFO, clears the slot pointer and valid_o, and drops any enable_i bundle on the same edge (flush wins).
  - overflow_o is unaffected.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally; full/empty are decided by count, never by pointer equality.
- Field extraction is pure bit slicing; there is no sign extension in this block.

Optional Feature:
- Macro: DECODE_NOP_SQUASH_EN.
- Defined: a slot whose opcode == 7'b0000000, in either format, is not loaded into the output.
  - The slot pointer advances (or the head pops) exactly as if it had issued.
  - The skip consumes that issue opportunity: valid_o goes low or holds per the normal rules.
  - A bundle of two NOPs is popped in two cycles with no issue.
- Undefined: NOPs are issued like any other instruction.

Decomposition:
- Shared package pa_isa_pkg holds:
  - field bit positions: FMT_BIT=29, BR_BIT=28, OPC_HI/LO=27/21, RD_HI/LO=20/16, RS_HI/LO=15/11, IMM_HI/LO=15/0;
  - INSTR_W=30, BUNDLE_W=60;
  - OPC_NOP=7'h00;
  - a decoded-instruction struct type.
- Sub-module bundle_fifo (parameter DEPTH, width BUNDLE_W):
  - ports: push, pop, flush, head data, count, full, empty;
  - asynchronous active-low reset of pointers and count.
- decode_issue holds the slot pointer, output register, stall and overflow logic.

Test Plan:
- Reset asserted mid-stream with valid_o high -> outputs immediately 0 and count 0; after release a new bundle issues normally.
- Bundle {1_0_0000100_00001_0x000A, 1_0_0000100_00010_0x0005}, ready_i=1 ->
  - cycle 1: valid_o=1, fmt=1, opcode=4, rd=1, imm=10;
  - cycle 2: opcode=4, rd=2, imm=5;
  - cycle 3: valid_o=0.
- ready_i=0 with DEPTH=4 and bundles every cycle ->
  - stall_o high once count reaches 3;
  - 5th accepted-attempt bundle sets overflow_o;
  - outputs held stable throughout.
- Three bundles buffered, then flush_i and enable_i on the same edge -> next cycle valid_o=0, count=0, stall_o=0; the flush-edge bundle never issues.
- Bundle {0_0_0000001_00001_00010_0..0, all-zero} ->
  - with DECODE_NOP_SQUASH_EN: one issue (opcode=1, rd=1, rs=2), then valid_o=0;
  - without: two issues, the second with opcode=0.
- Alternating ready_i across a wrap of the FIFO pointers (10 bundles) -> all 20 instructions issue in order with no loss or duplication.
